// File: rtl/ps2_mouse_device_model.sv
// PS/2 mouse device emulator: generates the PS/2 clock, answers host commands
// and streams 3-byte movement packets while data reporting is enabled.
module ps2_mouse_device_model #(
  parameter int CLK_HALF = 4000,
  parameter int RTS_MIN  = 10000,
  parameter int GAP_CLKS = 8000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire        CLK_MOUSE,
  inout  wire        DATA_MOUSE,
  input  logic       PKT_VALID,
  input  logic [7:0] PKT_STATUS,
  input  logic [7:0] PKT_DX,
  input  logic [7:0] PKT_DY,
  output logic       PKT_READY,
  output logic [7:0] CMD_BYTE,
  output logic       CMD_VALID,
  output logic       STREAMING,
  output logic [3:0] current_state
);
  localparam int MAX_A = (CLK_HALF > GAP_CLKS) ? CLK_HALF : GAP_CLKS;
  localparam int MAX_C = (MAX_A > RTS_MIN) ? MAX_A : RTS_MIN;
  localparam int TW    = $clog2(MAX_C + 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TX_HIGH  = 4'd1,
    TX_LOW   = 4'd2,
    GAP      = 4'd3,
    RTS_WAIT = 4'd4,
    RX_LOW   = 4'd5,
    RX_HIGH  = 4'd6,
    RX_ACK   = 4'd7,
    INHIBIT  = 4'd8
  } state_t;

  state_t        state, next_state;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic [TW-1:0] timer, low_cnt;
  logic          tc;
  logic [3:0]    bit_idx;
  logic [10:0]   tx_frame;
  logic [9:0]    rx_shift;
  logic          ack_phase;
  logic [7:0]    q [3];
  logic [1:0]    q_count;
  logic          clk_drive, data_drive;
  logic          start_tx, latch_pkt, rx_done, tx_done;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], CLK_MOUSE};
      data_sync <= {data_sync[0], DATA_MOUSE};
    end
  end

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign tc      = (timer == '0);
  assign rx_done = (state == RX_ACK) && ack_phase && tc;
  assign tx_done = (state == TX_LOW) && tc && (bit_idx == 4'd10);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_tx   = 1'b0;
    latch_pkt  = 1'b0;
    clk_drive  = 1'b0;
    data_drive = 1'b0;
    case (state)
      IDLE: begin
        if (!clk_s) next_state = INHIBIT;
        else if (q_count != 2'd0) begin
          next_state = TX_HIGH;
          start_tx   = 1'b1;
        end else if (STREAMING && PKT_VALID) latch_pkt = 1'b1;
      end
      TX_HIGH: begin
        data_drive = ~tx_frame[bit_idx];
        // the first two cycles still see our own low phase through the synchroniser
        if (!clk_s && timer <= TW'(CLK_HALF - 3)) next_state = INHIBIT;
        else if (tc) next_state = TX_LOW;
      end
      TX_LOW: begin
        data_drive = ~tx_frame[bit_idx];
        clk_drive  = 1'b1;
        if (tc) next_state = (bit_idx == 4'd10) ? GAP : TX_HIGH;
      end
      GAP: if (tc) next_state = IDLE;
      INHIBIT: begin
        if (clk_s) begin
          if (low_cnt == '0 && !data_s) next_state = RTS_WAIT;
          else if (tc) next_state = IDLE;
        end
      end
      RTS_WAIT: if (tc) next_state = RX_LOW;
      RX_LOW: begin
        clk_drive = 1'b1;
        if (tc) next_state = RX_HIGH;
      end
      RX_HIGH: if (tc) next_state = (bit_idx == 4'd9) ? RX_ACK : RX_LOW;
      RX_ACK: begin
        data_drive = 1'b1;
        clk_drive  = ack_phase;
        if (tc && ack_phase) next_state = GAP;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timer     <= '0;
      low_cnt   <= '0;
      bit_idx   <= '0;
      tx_frame  <= '1;
      rx_shift  <= '0;
      ack_phase <= 1'b0;
      q[0]      <= 8'hAA;
      q[1]      <= 8'h00;
      q[2]      <= 8'h00;
      q_count   <= 2'd2;
      PKT_READY <= 1'b0;
      CMD_VALID <= 1'b0;
      CMD_BYTE  <= 8'h00;
      STREAMING <= 1'b0;
    end else begin
      PKT_READY <= latch_pkt;
      CMD_VALID <= 1'b0;

      if (next_state != state)
        timer <= (next_state == GAP) ? TW'(GAP_CLKS - 1) : TW'(CLK_HALF - 1);
      else if ((state == INHIBIT && !clk_s) || (state == RX_ACK && tc && !ack_phase))
        timer <= TW'(CLK_HALF - 1);
      else if (!tc)
        timer <= timer - 1'b1;

      if (next_state == INHIBIT && state != INHIBIT)
        low_cnt <= TW'(RTS_MIN - 1);
      else if (state == INHIBIT && !clk_s && low_cnt != '0)
        low_cnt <= low_cnt - 1'b1;

      if (start_tx) begin
        tx_frame <= {1'b1, ~^q[0], q[0], 1'b0};
        bit_idx  <= '0;
      end else if ((state == TX_LOW && next_state == TX_HIGH) ||
                   (state == RX_HIGH && next_state == RX_LOW))
        bit_idx <= bit_idx + 1'b1;
      else if (state == RTS_WAIT)
        bit_idx <= '0;

      if (state == RX_HIGH && timer == TW'(CLK_HALF / 2))
        rx_shift <= {data_s, rx_shift[9:1]};

      if (state == RX_ACK && tc && !ack_phase) ack_phase <= 1'b1;
      else if (state != RX_ACK)                ack_phase <= 1'b0;

      // the head byte is only popped once its frame fully completes, so an
      // inhibited byte is naturally resent from its start bit
      if (tx_done) begin
        q[0]    <= q[1];
        q[1]    <= q[2];
        q_count <= q_count - 1'b1;
      end else if (latch_pkt) begin
        q[0]    <= PKT_STATUS | 8'h08;
        q[1]    <= PKT_DX;
        q[2]    <= PKT_DY;
        q_count <= 2'd3;
      end else if (rx_done) begin
        q_count <= 2'd1;
        if (rx_shift[9] && (^rx_shift[8:0])) begin
          CMD_VALID <= 1'b1;
          CMD_BYTE  <= rx_shift[7:0];
          q[0]      <= 8'hFA;
          case (rx_shift[7:0])
            8'hFF: begin
              q[1]      <= 8'hAA;
              q[2]      <= 8'h00;
              q_count   <= 2'd3;
              STREAMING <= 1'b0;
            end
            8'hF4:   STREAMING <= 1'b1;
            8'hF5:   STREAMING <= 1'b0;
            default: ;
          endcase
        end else begin
          q[0] <= 8'hFE;
        end
      end
    end
  end

  assign CLK_MOUSE     = clk_drive  ? 1'b0 : 1'bz;
  assign DATA_MOUSE    = data_drive ? 1'b0 : 1'bz;
  assign current_state = state;

endmodule

// File: tb/tb_ps2_mouse_device_model.sv
// Bench for ps2_mouse_device_model: a behavioural PS/2 host that listens to
// device frames, sends commands and exercises inhibit and mid-frame reset.
module tb_ps2_mouse_device_model;
  localparam int CLK_HALF = 8;
  localparam int RTS_MIN  = 24;
  localparam int GAP_CLKS = 20;
  localparam int TMO      = 2000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PKT_VALID = 1'b0;
  logic [7:0] PKT_STATUS = 8'h00, PKT_DX = 8'h00, PKT_DY = 8'h00;
  logic       PKT_READY, CMD_VALID, STREAMING;
  logic [7:0] CMD_BYTE;
  logic [3:0] current_state;
  logic       host_clk = 1'b0, host_data = 1'b0;
  wire        clk_line, data_line;

  pullup (clk_line);
  pullup (data_line);
  assign clk_line  = host_clk  ? 1'b0 : 1'bz;
  assign data_line = host_data ? 1'b0 : 1'bz;

  ps2_mouse_device_model #(.CLK_HALF(CLK_HALF), .RTS_MIN(RTS_MIN), .GAP_CLKS(GAP_CLKS)) dut (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE(clk_line), .DATA_MOUSE(data_line),
    .PKT_VALID(PKT_VALID), .PKT_STATUS(PKT_STATUS), .PKT_DX(PKT_DX), .PKT_DY(PKT_DY),
    .PKT_READY(PKT_READY), .CMD_BYTE(CMD_BYTE), .CMD_VALID(CMD_VALID),
    .STREAMING(STREAMING), .current_state(current_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int cyc = 0, first_fall = 0, end_cyc = 0;
  int cmd_hi = 0, pkt_hi = 0;
  logic [7:0] cmd_seen = 8'h00;
  logic       stream_at_cmd = 1'b0;

  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (CMD_VALID) begin
      cmd_hi++;
      cmd_seen = CMD_BYTE;
      stream_at_cmd = STREAMING;
    end
    if (PKT_READY) pkt_hi++;
  end

  typedef struct {
    logic [7:0]  cmd;
    bit          bad_par;
    int          nresp;
    logic [23:0] resp;      // first byte in [7:0]
    logic [2:0]  par;       // expected parity bit per response byte
    bit          exp_stream;
    int          exp_cmd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for PS/2 clock, expected activity within %0d cycles", name, TMO);
  endtask

  task automatic wait_level(input logic lvl, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (clk_line !== lvl) begin
      @(posedge CLK); #1;
      n++;
      if (n > TMO) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_fall(output bit ok);
    wait_level(1'b1, ok);
    if (ok) wait_level(1'b0, ok);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] b, input logic p);
    logic [10:0] f;
    bit ok, phase_bad;
    int w;
    f = '0;
    phase_bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wait_fall(ok);
      if (!ok) begin
        fail_to(tag);
        return;
      end
      if (i == 0) first_fall = cyc;
      f[i] = data_line;
      w = 0;
      while (clk_line === 1'b0 && w < TMO) begin
        @(posedge CLK); #1;
        w++;
        if (clk_line === 1'b0 && data_line !== f[i]) phase_bad = 1'b1;
      end
      if (w != CLK_HALF) phase_bad = 1'b1;
    end
    end_cyc = cyc;
    check({tag, " frame"}, 32'(f), 32'({1'b1, p, b, 1'b0}));
    check({tag, " low_phase"}, 32'(phase_bad), 32'd0);
  endtask

  task automatic host_send(input logic [7:0] b, input bit bad_par, output logic ack);
    logic [9:0] bits;
    bit ok;
    bits = {1'b1, (~^b) ^ bad_par, b};
    ack  = 1'b1;
    repeat (GAP_CLKS + 10) @(posedge CLK);
    #1 host_clk = 1'b1;
    repeat (RTS_MIN + 10) @(posedge CLK);
    #1 host_data = 1'b1;
    repeat (4) @(posedge CLK);
    #1 host_clk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_fall(ok);
      if (!ok) begin
        host_data = 1'b0;
        fail_to("host_send bit");
        return;
      end
      host_data = ~bits[i];
    end
    wait_fall(ok);
    if (!ok) begin
      fail_to("host_send ack");
      return;
    end
    ack = data_line;
    wait_level(1'b1, ok);
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    int c0;
    logic ack;
    c0 = cmd_hi;
    host_send(v.cmd, v.bad_par, ack);
    check({tag, " ack_bit"}, 32'(ack), 32'd0);
    for (int i = 0; i < v.nresp; i++)
      recv_byte($sformatf("%s resp%0d", tag, i), v.resp[8*i +: 8], v.par[i]);
    check({tag, " cmd_valid_cycles"}, 32'(cmd_hi - c0), 32'(v.exp_cmd));
    if (v.exp_cmd != 0) begin
      check({tag, " cmd_byte"}, 32'(cmd_seen), 32'(v.cmd));
      check({tag, " streaming_with_cmd"}, 32'(stream_at_cmd), 32'(v.exp_stream));
    end
    check({tag, " streaming"}, 32'(STREAMING), 32'(v.exp_stream));
    repeat (GAP_CLKS + 10) @(posedge CLK);
    #1 check({tag, " back_to_idle"}, 32'(current_state), 32'd0);
  endtask

  vec_t vecs [5];
  vec_t ff_vec;

  initial begin
    bit ok;
    int p0, aa_end;
    logic ack;

    vecs[0] = '{8'hF4, 1'b0, 1, 24'h0000FA, 3'b001, 1'b1, 1};
    vecs[1] = '{8'hF4, 1'b1, 1, 24'h0000FE, 3'b000, 1'b1, 0};
    vecs[2] = '{8'hF5, 1'b0, 1, 24'h0000FA, 3'b001, 1'b0, 1};
    vecs[3] = '{8'hE8, 1'b0, 1, 24'h0000FA, 3'b001, 1'b0, 1};
    vecs[4] = '{8'hF4, 1'b0, 1, 24'h0000FA, 3'b001, 1'b1, 1};
    ff_vec  = '{8'hFF, 1'b0, 3, 24'h00AAFA, 3'b111, 1'b0, 1};

    repeat (3) @(posedge CLK);
    #1;
    check("rst clk_line", 32'(clk_line), 32'd1);
    check("rst data_line", 32'(data_line), 32'd1);
    check("rst state", 32'(current_state), 32'd0);
    check("rst streaming", 32'(STREAMING), 32'd0);
    check("rst cmd_byte", 32'(CMD_BYTE), 32'd0);
    check("rst cmd_valid", 32'(CMD_VALID), 32'd0);
    check("rst pkt_ready", 32'(PKT_READY), 32'd0);
    RESET = 1'b0;

    recv_byte("boot AA", 8'hAA, 1'b1);
    aa_end = end_cyc;
    recv_byte("boot 00", 8'h00, 1'b1);
    check("boot gap_ge_gap_clks", 32'((first_fall - aa_end) >= GAP_CLKS), 32'd1);

    for (int i = 0; i < 5; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // movement packet while streaming
    p0 = pkt_hi;
    PKT_STATUS = 8'h01; PKT_DX = 8'h05; PKT_DY = 8'hFB; PKT_VALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      @(posedge CLK); #1;
      if (PKT_READY) ok = 1'b1;
    end
    PKT_VALID = 1'b0;
    if (!ok) fail_to("pkt ready");
    recv_byte("pkt status", 8'h09, 1'b1);
    recv_byte("pkt dx", 8'h05, 1'b1);
    recv_byte("pkt dy", 8'hFB, 1'b0);
    check("pkt ready_cycles", 32'(pkt_hi - p0), 32'd1);

    // inhibit after the 4th data bit of DX, then full resend of DX and DY
    repeat (GAP_CLKS + 10) @(posedge CLK);
    #1;
    p0 = pkt_hi;
    PKT_VALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      @(posedge CLK); #1;
      if (PKT_READY) ok = 1'b1;
    end
    PKT_VALID = 1'b0;
    if (!ok) fail_to("inh pkt ready");
    recv_byte("inh status", 8'h09, 1'b1);
    for (int i = 0; i < 5 && ok; i++) wait_fall(ok);
    if (ok) wait_level(1'b1, ok);
    if (!ok) fail_to("inh dx partial");
    host_clk = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("inh state", 32'(current_state), 32'd8);
    check("inh data_released", 32'(data_line), 32'd1);
    repeat (2 * RTS_MIN) @(posedge CLK);
    #1 host_clk = 1'b0;
    recv_byte("inh dx resend", 8'h05, 1'b1);
    recv_byte("inh dy", 8'hFB, 1'b0);
    check("inh ready_cycles", 32'(pkt_hi - p0), 32'd1);

    run_cmd("reset_cmd", ff_vec);
    p0 = pkt_hi;
    PKT_VALID = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    check("post_ff no_pkt_ready", 32'(pkt_hi - p0), 32'd0);
    check("post_ff state_idle", 32'(current_state), 32'd0);
    PKT_VALID = 1'b0;

    // asynchronous reset in the middle of the FA response frame
    host_send(8'hF4, 1'b0, ack);
    check("mid_rst ack_bit", 32'(ack), 32'd0);
    wait_fall(ok);
    if (ok) wait_fall(ok);
    if (!ok) fail_to("mid_rst frame");
    check("mid_rst clk_low_before", 32'(clk_line), 32'd0);
    RESET = 1'b1;
    #1;
    check("mid_rst clk_released", 32'(clk_line), 32'd1);
    check("mid_rst data_released", 32'(data_line), 32'd1);
    check("mid_rst state", 32'(current_state), 32'd0);
    check("mid_rst streaming", 32'(STREAMING), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    recv_byte("mid_rst AA", 8'hAA, 1'b1);
    recv_byte("mid_rst 00", 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
